// File: rtl/divisor_datapath.sv
// divisor_datapath
// Datapath of the sequential unsigned (restoring) divider. Holds the partial
// remainder A, the dividend/quotient shift register Q, the latched divisor B
// and the iteration counter CNT. It executes the INIT/SH/DEC/LDA/DV0 commands
// from the divider control FSM and returns the MSB/Z status bits to it.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a DZ flag is captured on INIT; while set, QUOTIENT reads all
//               ones and REMAINDER reads the dividend latched at INIT.
//   undefined : DIV_BY_ZERO is tied to 0; divide by zero runs the normal
//               algorithm.
//
// Ports
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset
//   DVND_IN     dividend, sampled on INIT
//   DVSR_IN     divisor, sampled on INIT
//   INIT        load operands, clear A, load CNT with WIDTH
//   SH          shift {A,Q} left one bit, insert 0
//   DEC         decrement CNT (saturates at 0)
//   LDA         load A with the trial difference
//   DV0         set Q[0]
//   MSB         sign of the trial difference (1 = A < B)
//   Z           CNT == 0
//   QUOTIENT    register Q
//   REMAINDER   A[WIDTH-1:0]
//   DIV_BY_ZERO divisor latched at INIT was 0 (macro only, else 0)
module divisor_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DVND_IN,
    input  logic [WIDTH-1:0] DVSR_IN,
    input  logic             INIT,
    input  logic             SH,
    input  logic             DEC,
    input  logic             LDA,
    input  logic             DV0,
    output logic             MSB,
    output logic             Z,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned DW = WIDTH + 2;

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    d;

    // Trial difference, one guard bit above A so the sign is never lost
    assign d   = {1'b0, a} - {2'b00, b};
    assign MSB = d[DW-1];
    assign Z   = (cnt == '0);

    // A / Q / B: INIT wins, then SH, then LDA/DV0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a <= '0;
            q <= '0;
            b <= '0;
        end else if (INIT) begin
            a <= '0;
            q <= DVND_IN;
            b <= DVSR_IN;
        end else if (SH) begin
            {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        end else begin
            if (LDA) begin
                a <= d[WIDTH:0];
            end
            if (DV0) begin
                q[0] <= 1'b1;
            end
        end
    end

    // Iteration counter, saturating at zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (INIT) begin
            cnt <= CW'(WIDTH);
        end else if (DEC && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic             dz;
    logic [WIDTH-1:0] dvnd_l;

    // Divide-by-zero flag and latched dividend, both refreshed on every INIT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dz     <= 1'b0;
            dvnd_l <= '0;
        end else if (INIT) begin
            dz     <= (DVSR_IN == '0);
            dvnd_l <= DVND_IN;
        end
    end

    assign DIV_BY_ZERO = dz;
    assign QUOTIENT    = dz ? '1 : q;
    assign REMAINDER   = dz ? dvnd_l : a[WIDTH-1:0];
`else
    assign DIV_BY_ZERO = 1'b0;
    assign QUOTIENT    = q;
    assign REMAINDER   = a[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_divisor_datapath.sv
// tb_divisor_datapath
// Directed bench for divisor_datapath (WIDTH=8). Acts as the control FSM,
// drives complete divisions and checks results against hand-computed values.
// Follows the DIV_ZERO_DETECT_EN macro for the divide-by-zero expectations.
module tb_divisor_datapath;

    localparam int unsigned WIDTH = 8;

    logic             CLK;
    logic             RST_N;
    logic [WIDTH-1:0] DVND_IN;
    logic [WIDTH-1:0] DVSR_IN;
    logic             INIT;
    logic             SH;
    logic             DEC;
    logic             LDA;
    logic             DV0;
    logic             MSB;
    logic             Z;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             DIV_BY_ZERO;

    int n_vec;
    int n_err;

    divisor_datapath #(.WIDTH(WIDTH)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .DVND_IN     (DVND_IN),
        .DVSR_IN     (DVSR_IN),
        .INIT        (INIT),
        .SH          (SH),
        .DEC         (DEC),
        .LDA         (LDA),
        .DV0         (DV0),
        .MSB         (MSB),
        .Z           (Z),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value with its expectation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold a command set for one clock; returns #1 after the edge
    task automatic step(input logic i, input logic s, input logic de, input logic l, input logic v);
        INIT = i; SH = s; DEC = de; LDA = l; DV0 = v;
        @(posedge CLK);
        #1;
        INIT = 1'b0; SH = 1'b0; DEC = 1'b0; LDA = 1'b0; DV0 = 1'b0;
    endtask

    // One FSM iteration: SH+DEC, check MSB, optional LDA+DV0
    task automatic iterate(inout int lda_n, inout int msb1_n);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (MSB) begin
            msb1_n++;
        end else begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            lda_n++;
        end
    endtask

    // Full division, bounded to WIDTH+2 iterations
    task automatic run_div(input logic [WIDTH-1:0] dvnd, input logic [WIDTH-1:0] dvsr,
                           output int iters, output int lda_n, output int msb1_n);
        DVND_IN = dvnd;
        DVSR_IN = dvsr;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        iters  = 0;
        lda_n  = 0;
        msb1_n = 0;
        do begin
            iterate(lda_n, msb1_n);
            iters++;
        end while (!Z && iters < int'(WIDTH) + 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int it, ln, mn;
        n_vec = 0;
        n_err = 0;
        RST_N = 1'b0;
        DVND_IN = '0; DVSR_IN = '0;
        INIT = 1'b0; SH = 1'b0; DEC = 1'b0; LDA = 1'b0; DV0 = 1'b0;
        #12;
        check("rst_z",   32'(Z), 1);
        check("rst_msb", 32'(MSB), 0);
        check("rst_q",   32'(QUOTIENT), 0);
        check("rst_r",   32'(REMAINDER), 0);
        check("rst_dz",  32'(DIV_BY_ZERO), 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // 100 / 7 = 14 r 2
        run_div(8'd100, 8'd7, it, ln, mn);
        check("d100_iters", 32'(it), 8);
        check("d100_q", 32'(QUOTIENT), 14);
        check("d100_r", 32'(REMAINDER), 2);
        check("d100_z", 32'(Z), 1);

        // SH with LDA and DV0: only the shift lands (A=2,Q=14 -> A=4,Q=28)
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("shprio_q", 32'(QUOTIENT), 28);
        check("shprio_r", 32'(REMAINDER), 4);

        // DEC at zero must not wrap
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("dec_hold_z", 32'(Z), 1);
            check("dec_hold_cnt", 32'(dut.cnt), 0);
        end

        // 255 / 1: subtract every iteration
        run_div(8'd255, 8'd1, it, ln, mn);
        check("d255_q", 32'(QUOTIENT), 255);
        check("d255_r", 32'(REMAINDER), 0);
        check("d255_lda", 32'(ln), 8);

        // 5 / 9: never subtract
        run_div(8'd5, 8'd9, it, ln, mn);
        check("d5_q", 32'(QUOTIENT), 0);
        check("d5_r", 32'(REMAINDER), 5);
        check("d5_msb1", 32'(mn), 8);

        // 37 / 0
        run_div(8'd37, 8'd0, it, ln, mn);
        check("dz_q", 32'(QUOTIENT), 255);
        check("dz_r", 32'(REMAINDER), 37);
`ifdef DIV_ZERO_DETECT_EN
        check("dz_flag", 32'(DIV_BY_ZERO), 1);
`else
        check("dz_flag", 32'(DIV_BY_ZERO), 0);
`endif
        run_div(8'd9, 8'd3, it, ln, mn);
        check("d9_q", 32'(QUOTIENT), 3);
        check("d9_r", 32'(REMAINDER), 0);
        check("d9_dz", 32'(DIV_BY_ZERO), 0);

        // INIT overrides every other command
        DVND_IN = 8'd9;
        DVSR_IN = 8'd3;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("initprio_q", 32'(QUOTIENT), 9);
        check("initprio_r", 32'(REMAINDER), 0);
        check("initprio_z", 32'(Z), 0);

        // Reset after 4 iterations of 200 / 13, checked without a clock edge
        DVND_IN = 8'd200;
        DVSR_IN = 8'd13;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ln = 0;
        mn = 0;
        for (int k = 0; k < 4; k++) iterate(ln, mn);
        check("mid_z", 32'(Z), 0);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_q",   32'(QUOTIENT), 0);
        check("arst_r",   32'(REMAINDER), 0);
        check("arst_z",   32'(Z), 1);
        check("arst_msb", 32'(MSB), 0);
        check("arst_dz",  32'(DIV_BY_ZERO), 0);
        #3;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        run_div(8'd200, 8'd13, it, ln, mn);
        check("d200_iters", 32'(it), 8);
        check("d200_q", 32'(QUOTIENT), 15);
        check("d200_r", 32'(REMAINDER), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
